seq_div16: RTL

Multi-cycle unsigned radix-2 restoring divider. It is the inverse-operation companion to the recursive 16-bit multipliers. It takes a dividend/divisor pair through a valid/ready handshake, computes one quotient bit per clock, and presents the quotient and remainder through a held valid/ready output. It is used to verify the multiplier datapath (product ÷ operand checks) and in ratio and normalisation paths of the error-evaluation flow.

---
 rtl/seq_div16.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_div16.sv
// rtl/seq_div16.sv - multi-cycle unsigned radix-2 restoring divider with valid/ready handshakes
// One quotient bit per clock; results held until the consumer takes them.
module seq_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             out_valid_q;

    logic [WIDTH:0]   t_d;
    logic             ge_d;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;

    // Partial remainder always stays below D, so the subtraction fits in WIDTH bits
    // even though the trial value needs WIDTH+1 bits for the compare.
    always_comb begin
        t_d  = {r_q, q_q[WIDTH-1]};
        ge_d = (t_d >= {1'b0, d_q});
        r_d  = ge_d ? (t_d[WIDTH-1:0] - d_q) : t_d[WIDTH-1:0];
        q_d  = {q_q[WIDTH-2:0], ge_d};
    end

    assign in_ready    = (state_q == IDLE) && rst_n;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor != '0) begin
                            d_q     <= divisor;
                            q_q     <= dividend;
                            r_q     <= '0;
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end else begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                        dbz_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // A zero-divisor result enters DONE without valid; it is raised one edge later.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
